// File: rtl/irq_debouncer.sv
// rtl/irq_debouncer.sv - per-line two-flop synchronizer and consecutive-cycle debouncer for IRQ levels
// Defining IRQ_DEBOUNCER_MASK_EN adds irq_mask_bi, which forces masked output lines low.
module irq_debouncer #(
  parameter int IRQ_NUM_POW     = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [(2**IRQ_NUM_POW)-1:0]   irq_bi,
`ifdef IRQ_DEBOUNCER_MASK_EN
  input  logic [(2**IRQ_NUM_POW)-1:0]   irq_mask_bi,
`endif
  output logic [(2**IRQ_NUM_POW)-1:0]   irq_debounced_bo
);

  localparam int IRQ_NUM = 2 ** IRQ_NUM_POW;
  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [IRQ_NUM-1:0] sync0_q, sync0_d;
  logic [IRQ_NUM-1:0] sync1_q, sync1_d;
  logic [IRQ_NUM-1:0] stable_q, stable_d;
  logic [CW-1:0]      cnt_q [IRQ_NUM];
  logic [CW-1:0]      cnt_d [IRQ_NUM];

  // cnt counts consecutive cycles sync1 disagrees with the accepted level; any agreement restarts it.
  always_comb begin
    sync0_d  = irq_bi;
    sync1_d  = sync0_q;
    stable_d = stable_q;
    for (int i = 0; i < IRQ_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync1_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync1_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      stable_q <= stable_d;
      for (int i = 0; i < IRQ_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef IRQ_DEBOUNCER_MASK_EN
  // Unmasking a line already stable high yields a fresh rising edge for the adapter.
  assign irq_debounced_bo = stable_q & ~irq_mask_bi;
`else
  assign irq_debounced_bo = stable_q;
`endif

endmodule
